// File: rtl/maxnet_round_sequencer_if.sv
// maxnet_round_sequencer_if: control, mux-feed and PE handshake bundle of the Maxnet round sequencer
interface maxnet_round_sequencer_if #(parameter int RC_W = 5);
  logic start;
  logic [127:0] init_data;
  logic [31:0] act_1, act_2, act_3, act_4;
  logic [1:0] mux_select;
  logic pe_valid, pe_ready, res_valid;
  logic [31:0] res_data;
  logic busy, done, winner_valid, timeout;
  logic [1:0] winner_idx;
  logic [RC_W-1:0] round_count;
  modport master(
    output start, init_data, pe_ready, res_valid, res_data,
    input act_1, act_2, act_3, act_4, mux_select, pe_valid, busy, done, winner_valid, winner_idx,
          timeout, round_count
  );
  modport slave(
    input start, init_data, pe_ready, res_valid, res_data,
    output act_1, act_2, act_3, act_4, mux_select, pe_valid, busy, done, winner_valid, winner_idx,
           timeout, round_count
  );
endinterface

// File: rtl/maxnet_round_sequencer.sv
// maxnet_round_sequencer: feeds four activations through the PE mux one slot at a time and commits each round synchronously
module maxnet_round_sequencer #(
  parameter int MAX_ROUNDS = 16,
  parameter int RC_W = 5
) (
  input logic clk,
  input logic rst,
  maxnet_round_sequencer_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, SEND = 3'd1, WAIT = 3'd2, COMMIT = 3'd3, CHECK = 3'd4, DONE = 3'd5;
  localparam logic [RC_W-1:0] MAX_RC = RC_W'(MAX_ROUNDS);
  logic [2:0] state;
  logic [1:0] slot, first, widx;
  logic [31:0] act [4];
  logic [31:0] shadow [4];
  logic [3:0] pos;
  logic [2:0] pcnt;
  logic [RC_W-1:0] rc;
  logic wv, to;
  // sign-and-magnitude positivity works for both float and two's complement
  always_comb begin
    for (int i = 0; i < 4; i++) pos[i] = !act[i][31] && |act[i][30:0];
    pcnt = 3'(pos[0]) + 3'(pos[1]) + 3'(pos[2]) + 3'(pos[3]);
    first = pos[0] ? 2'd0 : pos[1] ? 2'd1 : pos[2] ? 2'd2 : pos[3] ? 2'd3 : 2'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      slot <= '0;
      act <= '{default: '0};
      shadow <= '{default: '0};
      rc <= '0;
      wv <= 1'b0;
      widx <= '0;
      to <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (bus.start) begin
          act[0] <= bus.init_data[31:0];
          act[1] <= bus.init_data[63:32];
          act[2] <= bus.init_data[95:64];
          act[3] <= bus.init_data[127:96];
          rc <= '0;
          slot <= '0;
          wv <= 1'b0;
          widx <= '0;
          to <= 1'b0;
          state <= SEND;
        end
        SEND: if (bus.pe_ready) state <= WAIT;
        WAIT: if (bus.res_valid) begin
          shadow[slot] <= bus.res_data;
          slot <= slot + 2'd1;
          state <= slot == 2'd3 ? COMMIT : SEND;
        end
        COMMIT: begin
          act <= shadow;
          rc <= rc + 1'b1;
          slot <= '0;
          state <= CHECK;
        end
        CHECK: if (pcnt <= 3'd1 || rc == MAX_RC) begin
          wv <= pcnt == 3'd1;
          widx <= first;
          to <= pcnt > 3'd1;
          state <= DONE;
        end else state <= SEND;
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.act_1 = act[0];
  assign bus.act_2 = act[1];
  assign bus.act_3 = act[2];
  assign bus.act_4 = act[3];
  assign bus.mux_select = slot;
  assign bus.pe_valid = state == SEND;
  assign bus.busy = state != IDLE && state != DONE;
  assign bus.done = state == DONE;
  assign bus.winner_valid = wv;
  assign bus.winner_idx = widx;
  assign bus.timeout = to;
  assign bus.round_count = rc;
endmodule

// File: tb/tb_maxnet_round_sequencer.sv
// tb_maxnet_round_sequencer: directed checks of the Maxnet round sequencer against a PE model and a real-valued golden model
module tb_maxnet_round_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  maxnet_round_sequencer_if #(.RC_W(5)) bus();
  maxnet_round_sequencer #(.MAX_ROUNDS(4), .RC_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, errors = 0;
  int mode = 0, stall = 0, cyc = 0, gr = 0, gi = 0;
  bit inject = 1'b0, pend = 1'b0, gw = 1'b0;
  logic [31:0] pend_data = '0;
  localparam logic [127:0] INIT_A = {32'h3DCCCCCD, 32'h3F000000, 32'h3F666666, 32'h3E4CCCCD};
  localparam logic [127:0] INIT_EQ = {4{32'h3F000000}};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic real f2r(input logic [31:0] f);
    if (f[30:23] == 8'd0) return 0.0;
    return $bitstoreal({f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0});
  endfunction
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    if (r <= 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction
  // mode 0: maxnet update with eps=0.2; mode 1: identity; mode 2: -0 / 0 alternating
  function automatic logic [31:0] pe_fn(input logic [1:0] s);
    logic [31:0] a [4];
    real sum;
    a = '{bus.act_1, bus.act_2, bus.act_3, bus.act_4};
    sum = f2r(a[0]) + f2r(a[1]) + f2r(a[2]) + f2r(a[3]);
    return mode == 1 ? a[s] : mode == 2 ? (s[0] ? 32'h0 : 32'h80000000)
                   : r2f(f2r(a[s]) - 0.2 * (sum - f2r(a[s])));
  endfunction
  function automatic void golden(input real iv [4], output int rounds, output int widx, output bit wv);
    real v [4];
    real nv [4];
    real s;
    int p;
    v = iv;
    rounds = 0;
    do begin
      s = v[0] + v[1] + v[2] + v[3];
      for (int i = 0; i < 4; i++) begin
        nv[i] = v[i] - 0.2 * (s - v[i]);
        if (nv[i] < 0.0) nv[i] = 0.0;
      end
      v = nv;
      rounds++;
      p = 0;
      widx = 0;
      for (int i = 3; i >= 0; i--) if (v[i] > 0.0) begin p++; widx = i; end
    end while (p > 1 && rounds < 4);
    wv = p == 1;
  endfunction
  initial begin
    bus.pe_ready = 1'b1;
    bus.res_valid = 1'b0;
    bus.res_data = '0;
    forever @(negedge clk) begin
      bus.res_valid = 1'b0;
      if (rst) pend = 1'b0;
      else if (pend) begin
        bus.res_valid = 1'b1;
        bus.res_data = pend_data;
        pend = 1'b0;
      end else if (inject && bus.pe_valid) begin
        bus.res_valid = 1'b1;
        bus.res_data = 32'h7F000000;
        inject = 1'b0;
      end
      bus.pe_ready = !(stall > 0 && bus.pe_valid && bus.mux_select == 2'd1);
      if (!bus.pe_ready) stall--;
      if (bus.pe_valid && bus.pe_ready) begin
        pend = 1'b1;
        pend_data = pe_fn(bus.mux_select);
      end
    end
  end
  task automatic chk_reset(input string tag);
    chk({tag, "_act1"}, bus.act_1, 32'h0);
    chk({tag, "_act2"}, bus.act_2, 32'h0);
    chk({tag, "_act3"}, bus.act_3, 32'h0);
    chk({tag, "_act4"}, bus.act_4, 32'h0);
    chk({tag, "_sel"}, 32'(bus.mux_select), 32'd0);
    chk({tag, "_pe_valid"}, 32'(bus.pe_valid), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_wv"}, 32'(bus.winner_valid), 32'd0);
    chk({tag, "_widx"}, 32'(bus.winner_idx), 32'd0);
    chk({tag, "_timeout"}, 32'(bus.timeout), 32'd0);
    chk({tag, "_rc"}, 32'(bus.round_count), 32'd0);
  endtask
  task automatic launch(input logic [127:0] init);
    @(negedge clk);
    bus.init_data = init;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    cyc = 0;
    while (!bus.done && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask
  task automatic result(input string tag, input int rc, input bit wv, input int widx, input bit to);
    chk({tag, "_rc"}, 32'(bus.round_count), 32'(rc));
    chk({tag, "_wv"}, 32'(bus.winner_valid), 32'(wv));
    chk({tag, "_widx"}, 32'(bus.winner_idx), 32'(widx));
    chk({tag, "_timeout"}, 32'(bus.timeout), 32'(to));
  endtask
  initial begin
    bus.start = 1'b0;
    bus.init_data = '0;
    repeat (2) @(negedge clk);
    chk_reset("por");
    rst = 1'b0;
    mode = 1;
    launch(INIT_EQ);
    cyc = 0;
    while (!(bus.busy && !bus.pe_valid && bus.mux_select == 2'd2) && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("mid_wait_slot2", 32'(bus.mux_select), 32'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset("mid_rst");
    @(negedge clk);
    bus.init_data = INIT_EQ;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_vs_start_busy", 32'(bus.busy), 32'd0);
    chk("rst_vs_start_act1", bus.act_1, 32'h0);
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b0;
    mode = 0;
    golden('{0.2, 0.9, 0.5, 0.1}, gr, gi, gw);
    launch(INIT_A);
    wait_done("maxnet");
    result("maxnet", gr, gw, gi, 1'b0);
    chk("maxnet_widx_const", 32'(bus.winner_idx), 32'd1);
    chk("maxnet_act1", bus.act_1, 32'h0);
    chk("maxnet_act4", bus.act_4, 32'h0);
    launch(INIT_A);
    repeat (3) @(negedge clk);
    bus.init_data = INIT_EQ;
    bus.start = 1'b1;
    inject = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("ignored");
    result("ignored", gr, gw, gi, 1'b0);
    mode = 1;
    launch(INIT_EQ);
    wait_done("maxround");
    result("maxround", 4, 1'b0, 0, 1'b1);
    chk("maxround_cycles", 32'(cyc), 32'd40);
    chk("maxround_act3", bus.act_3, 32'h3F000000);
    stall = 5;
    launch(INIT_EQ);
    cyc = 0;
    while (!(bus.pe_valid && bus.mux_select == 2'd1) && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall_sel", 32'(bus.mux_select), 32'd1);
      chk("stall_pe_valid", 32'(bus.pe_valid), 32'd1);
    end
    wait_done("stall");
    result("stall", 4, 1'b0, 0, 1'b1);
    mode = 2;
    launch({32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000});
    wait_done("nonpos");
    result("nonpos", 1, 1'b0, 0, 1'b0);
    chk("nonpos_cycles", 32'(cyc), 32'd10);
    chk("nonpos_act1", bus.act_1, 32'h80000000);
    chk("nonpos_act2", bus.act_2, 32'h0);
    mode = 1;
    launch({32'h0, 32'h40000000, 32'h0, 32'h0});
    wait_done("single");
    result("single", 1, 1'b1, 2, 1'b0);
    chk("single_cycles", 32'(cyc), 32'd10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
